instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, fetch-wait limit in cycles when FETCH_TIMEOUT_EN is defined.
REQ-003 The block SHALL provide these ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the current instruction in EXEC.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  32  read address; equals pc.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word.
- beq, bne, jump  in  1 each  decoded control for the held instruction.
- zero  in  1  ALU zero flag for the held instruction.
- instr  out  32  instruction register.
- opcode  out  6  instr[31:26], to control decode.
- pc  out  32  address of the held instruction.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- instr_valid  out  1  instr/opcode hold a fetched word.
- fetch_err  out  1  sticky timeout flag.

Function
REQ-004 The block SHALL be a two-state FSM: FETCH and EXEC.
REQ-005 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-006 In FETCH with imem_ack=1, the block SHALL load instr from imem_rdata, set instr_valid=1, and go to EXEC on the next edge. Same-cycle ack is legal, so the minimum is 2 cycles per instruction.
REQ-007 In FETCH with imem_ack=0, the block SHALL remain in FETCH with imem_req=1 and pc unchanged.
REQ-008 In EXEC, imem_req SHALL be 0, and imem_ack SHALL be ignored.
REQ-009 In EXEC with stall=1, all state SHALL be held.
REQ-010 In EXEC with stall=0, the block SHALL load pc with next_pc, clear instr_valid, and return to FETCH.
REQ-011 The block SHALL select next_pc by priority:
- jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
- else taken=(beq&zero)|(bne&~zero): pc_plus4 + (sign_extend(instr[15:0])<<2), modulo 2^32.
- else: pc_plus4.
REQ-012 beq, bne, jump and zero SHALL be sampled only on the EXEC exit edge; their values in other cycles SHALL have no effect.
REQ-013 stall asserted in FETCH SHALL be ignored.
REQ-014 pc SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without error.
REQ-015 pc[1:0] SHALL always be 2'b00. Branch and jump arithmetic preserves this, and RESET_PC[1:0] is masked to 00.
REQ-016 opcode SHALL be combinationally instr[31:26].
REQ-017 pc_plus4 SHALL be combinationally pc+4.

Reset
REQ-018 When reset=1 at a clock edge, the block SHALL set pc=RESET_PC, state=FETCH, instr=0, instr_valid=0 and fetch_err=0, and SHALL clear the timeout counter.
REQ-019 imem_req SHALL be 0 while reset is high. It SHALL be 1 in the first cycle after reset deasserts.
REQ-020 Reset mid-fetch SHALL abandon the pending request. An ack arriving in the same cycle as reset SHALL be discarded.

Configuration
REQ-021 Macro FETCH_TIMEOUT_EN SHALL control the fetch timeout feature.
REQ-022 When FETCH_TIMEOUT_EN is defined:
- An 8-bit counter SHALL count consecutive FETCH cycles without ack.
- At count == TIMEOUT_CYCLES, fetch_err SHALL be set and stay set until reset.
- At the same point, the counter SHALL clear and the request SHALL continue (retry at the same pc).
- Entering EXEC SHALL clear the counter.
REQ-023 When FETCH_TIMEOUT_EN is undefined, the counter SHALL be absent and fetch_err SHALL be tied to 0.

Verification
REQ-024 Sequential: reset, then ack on every request with rdata=32'h0000_0020 and stall=0 -> pc goes 0,4,8,C, with instr_valid high every second cycle.
REQ-025 Taken beq: pc=0x10, instr=32'h1000_0003, beq=1, zero=1 on EXEC exit -> next pc=0x20. The same case with zero=0 -> next pc=0x14.
REQ-026 Jump priority: pc=0x40, instr=32'h0800_0100, jump=1, beq=1, zero=1 -> next pc=0x400.
REQ-027 Stall and late ack:
- Ack delayed 3 cycles -> imem_req held 3 cycles, pc constant.
- Then stall=1 for 5 cycles in EXEC -> instr and pc stable, imem_req=0.
REQ-028 Wrap and reset:
- RESET_PC=32'hFFFF_FFFC, one instruction -> next pc=0.
- reset asserted while imem_req=1, with a simultaneous ack -> instr=0, instr_valid=0.
REQ-029 With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> fetch_err=1 after 4 FETCH cycles, request still active. fetch_err stays 1 after a later ack and clears only on reset.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: FETCH/EXEC FSM holding one instruction and computing the next pc.
// Optional fetch-wait timeout with a sticky error flag is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        beq,
    input  logic        bne,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        fetch_err
);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    // Low address bits are forced to zero so pc stays word aligned from reset onward.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    // The wait counter is 8 bits wide, so the limit must fit.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_check
        $error("instr_fetch: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] instr_reg;
    logic [31:0] instr_next;
    logic        valid_reg;
    logic        valid_next;

    logic [31:0] seq_pc;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        taken;
    logic [31:0] redirect_pc;
    logic        exec_exit;
    logic        fetch_done;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:   if (imem_ack) state_next = EXEC;
            EXEC:    if (!stall)   state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // ---------------- FSM: output logic ----------------
    // Request is masked during reset so a pending fetch is abandoned immediately.
    always_comb begin
        imem_req   = 1'b0;
        fetch_done = 1'b0;
        exec_exit  = 1'b0;
        case (state_reg)
            FETCH: begin
                imem_req   = ~reset;
                fetch_done = imem_ack;
            end
            EXEC: begin
                exec_exit = ~stall;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    // ---------------- next-pc selection ----------------
    always_comb begin
        seq_pc        = pc_reg + 32'd4;
        branch_offset = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
        branch_target = seq_pc + branch_offset;
        jump_target   = {seq_pc[31:28], instr_reg[25:0], 2'b00};
        taken         = (beq & zero) | (bne & ~zero);
        if (jump) begin
            redirect_pc = jump_target;
        end else if (taken) begin
            redirect_pc = branch_target;
        end else begin
            redirect_pc = seq_pc;
        end
    end

    // ---------------- datapath next values ----------------
    // Control inputs only matter on the EXEC exit edge; elsewhere pc simply holds.
    always_comb begin
        pc_next    = pc_reg;
        instr_next = instr_reg;
        valid_next = valid_reg;
        if (fetch_done) begin
            instr_next = imem_rdata;
            valid_next = 1'b1;
        end
        if (exec_exit) begin
            pc_next    = redirect_pc;
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg    <= RESET_PC_ALIGNED;
            instr_reg <= 32'd0;
            valid_reg <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            valid_reg <= valid_next;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] wait_cnt_reg;
    logic [7:0] wait_cnt_next;
    logic       fetch_err_reg;
    logic       fetch_err_next;

    // Counts consecutive unacknowledged FETCH cycles; on hitting the limit the
    // error latches and the count restarts while the request keeps retrying.
    always_comb begin
        wait_cnt_next  = wait_cnt_reg;
        fetch_err_next = fetch_err_reg;
        if (state_reg == FETCH) begin
            if (imem_ack) begin
                wait_cnt_next = 8'd0;
            end else if (wait_cnt_reg + 8'd1 == TIMEOUT_LIMIT) begin
                wait_cnt_next  = 8'd0;
                fetch_err_next = 1'b1;
            end else begin
                wait_cnt_next = wait_cnt_reg + 8'd1;
            end
        end else begin
            wait_cnt_next = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg  <= 8'd0;
            fetch_err_reg <= 1'b0;
        end else begin
            wait_cnt_reg  <= wait_cnt_next;
            fetch_err_reg <= fetch_err_next;
        end
    end

    assign fetch_err = fetch_err_reg;
`else
    assign fetch_err = 1'b0;
`endif

    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign pc_plus4    = seq_pc;
    assign instr       = instr_reg;
    assign opcode      = instr_reg[31:26];
    assign instr_valid = valid_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: fetched words are queued when acked and checked in EXEC.
// Covers sequential flow, branches, jump priority, stalls, late acks, pc wrap, reset and timeout.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        beq;
    logic        bne;
    logic        jump;
    logic        zero;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

`ifdef FETCH_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
    } sb_entry_t;

    sb_entry_t   sb[$];
    logic [31:0] model_pc;

    instr_fetch #(
        .RESET_PC      (32'h0000_0000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .beq        (beq),
        .bne        (bne),
        .jump       (jump),
        .zero       (zero),
        .instr      (instr),
        .opcode     (opcode),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instr_valid(instr_valid),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input logic b_eq, input logic b_ne,
                                               input logic jmp, input logic zf);
        logic [31:0] p4;
        int signed   off;
        p4  = p + 32'd4;
        off = int'($signed(w[15:0])) * 4;
        if (jmp) return {p4[31:28], w[25:0], 2'b00};
        if ((b_eq && zf) || (b_ne && !zf)) return p4 + 32'(off);
        return p4;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete instruction: delay FETCH cycles without ack, ack, then
    // stalls EXEC cycles with stall=1 and one exit cycle carrying the controls.
    task automatic fetch_one(input logic [31:0] word, input int delay,
                             input logic b_eq, input logic b_ne, input logic jmp,
                             input logic zf, input int stalls);
        sb_entry_t exp;
        for (int i = 0; i < delay; i++) begin
            imem_ack = 1'b0;
            stall    = 1'($urandom_range(0, 1));
            {beq, bne, jump, zero} = 4'($urandom);
            @(negedge clk);
            check("req_wait", 32'(imem_req), 32'd1);
            check("addr_wait", imem_addr, model_pc);
            check("pc_wait", pc, model_pc);
            step();
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        stall      = 1'($urandom_range(0, 1));
        sb.push_back('{addr: model_pc, word: word});
        @(negedge clk);
        check("req_ack", 32'(imem_req), 32'd1);
        check("addr_ack", imem_addr, model_pc);
        check("valid_fetch", 32'(instr_valid), 32'd0);
        step();
        imem_rdata = $urandom;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        exp = sb.pop_front();
        for (int i = 0; i <= stalls; i++) begin
            imem_ack = 1'($urandom_range(0, 1));
            if (i < stalls) begin
                stall = 1'b1;
                {beq, bne, jump, zero} = 4'($urandom);
            end else begin
                stall = 1'b0;
                beq   = b_eq;
                bne   = b_ne;
                jump  = jmp;
                zero  = zf;
            end
            @(negedge clk);
            check("req_exec", 32'(imem_req), 32'd0);
            check("pc_exec", pc, exp.addr);
            check("instr_exec", instr, exp.word);
            check("opcode", 32'(opcode), 32'(exp.word[31:26]));
            check("pc_plus4", pc_plus4, exp.addr + 32'd4);
            check("valid_exec", 32'(instr_valid), 32'd1);
            check("err_exec", 32'(fetch_err), 32'd0);
            step();
        end
        {stall, imem_ack, beq, bne, jump, zero} = 6'd0;
        model_pc = model_next(exp.addr, exp.word, b_eq, b_ne, jmp, zf);
        $display("txn pc=%h instr=%h ctrl beq=%0b bne=%0b jump=%0b zero=%0b next=%h",
                 exp.addr, exp.word, b_eq, b_ne, jmp, zf, model_pc);
        @(negedge clk);
        check("next_pc", pc, model_pc);
        check("valid_clear", 32'(instr_valid), 32'd0);
        step();
    endtask

    initial begin
        reset = 1'b1;
        {stall, imem_ack, beq, bne, jump, zero} = 6'd0;
        imem_rdata = 32'd0;
        model_pc   = 32'h0000_0000;
        step();
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_pc", pc, 32'h0000_0000);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req", 32'(imem_req), 32'd1);
        step();
        // Already one FETCH cycle elapsed without ack; continue in FETCH.

        // Sequential fetches 0,4,8,C.
        for (int i = 0; i < 4; i++) fetch_one(32'h0000_0020, 0, 0, 0, 0, 0, 0);
        check("seq_pc", pc, 32'h0000_0010);
        // Taken beq at 0x10 -> 0x20.
        fetch_one(32'h1000_0003, 0, 1, 0, 0, 1, 0);
        // Jump back to 0x10, then not-taken beq -> 0x14.
        fetch_one(32'h0800_0004, 0, 0, 0, 1, 0, 0);
        fetch_one(32'h1000_0003, 0, 1, 0, 0, 0, 0);
        check("beq_nt_pc", pc, 32'h0000_0014);
        // Jump to 0x40, then jump beats taken beq -> 0x400.
        fetch_one(32'h0800_0010, 0, 0, 0, 1, 0, 0);
        fetch_one(32'h0800_0100, 0, 1, 0, 1, 1, 0);
        check("jump_prio_pc", pc, 32'h0000_0400);
        // Late ack (3 cycles) and 5-cycle stall; taken bne.
        fetch_one(32'h1400_0010, 3, 0, 1, 0, 0, 5);
        // Jump to 0, backward branch to 0xFFFFFFFC, then wrap to 0.
        fetch_one(32'h0800_0000, 1, 0, 0, 1, 0, 2);
        fetch_one(32'h1000_FFFE, 0, 1, 0, 0, 1, 0);
        check("pre_wrap_pc", pc, 32'hFFFF_FFFC);
        fetch_one(32'h0000_0020, 0, 0, 0, 0, 0, 0);
        check("wrap_pc", pc, 32'h0000_0000);

        for (int i = 0; i < 10; i++) begin
            fetch_one($urandom, int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        // Reset during an active request with a simultaneous ack.
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rst_mid_req", 32'(imem_req), 32'd0);
        step();
        reset    = 1'b0;
        imem_ack = 1'b0;
        model_pc = 32'h0000_0000;
        @(negedge clk);
        check("rst_mid_instr", instr, 32'd0);
        check("rst_mid_valid", 32'(instr_valid), 32'd0);
        check("rst_mid_pc", pc, 32'h0000_0000);
        check("rst_mid_req_after", 32'(imem_req), 32'd1);
        $display("txn reset mid-fetch pc=%h instr=%h valid=%0b", pc, instr, instr_valid);

        // Timeout: four FETCH cycles without ack.
        for (int i = 1; i <= 4; i++) begin
            check("err_before_limit", 32'(fetch_err), 32'd0);
            step();
            @(negedge clk);
        end
        check("err_at_limit", 32'(fetch_err), 32'(TIMEOUT_ON));
        check("req_at_limit", 32'(imem_req), 32'd1);
        check("addr_at_limit", imem_addr, 32'h0000_0000);
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0020;
        step();
        imem_ack = 1'b0;
        @(negedge clk);
        check("valid_after_late_ack", 32'(instr_valid), 32'd1);
        check("err_sticky", 32'(fetch_err), 32'(TIMEOUT_ON));
        $display("txn timeout fetch_err=%0b valid=%0b", fetch_err, instr_valid);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("err_cleared", 32'(fetch_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
